shift_right_seq: RTL and testbench

Multi-cycle 32-bit right shifter for the MIPS datapath. Executes SRL/SRA-class operations one bit position per clock under a start/busy/done handshake. It is the right-shift counterpart to the combinational left shifter and lets the multi-cycle control FSM sequence shift instructions without a full barrel shifter. Sits beside the ALU; result feeds the ALUOut register path.

---
 rtl/shift_right_seq.sv | 129 ++++++++++++
 tb/tb_shift_right_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: one bit position per clock under a start/busy/done handshake.
// Define SHIFT_RIGHT_ARITH_EN to honour the arith input (sign fill); otherwise logical only.
`timescale 1ns/1ps

module shift_right_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [4:0]       shamt,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [4:0]       count_q, count_d;
    logic             fill;
    logic             accept;

    // A new request is only taken when no operation is in flight.
    assign accept = start && ((state_q == StIdle) || (state_q == StDone));

`ifdef SHIFT_RIGHT_ARITH_EN
    logic mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (accept) begin
            mode_d = arith;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign fill = mode_q & data_q[WIDTH-1];
`else
    logic unused_arith;
    assign unused_arith = arith;
    assign fill         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (shamt != 5'd0) ? StShift : StDone;
                end
            end
            StShift: begin
                if (count_q == 5'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    state_d = (shamt != 5'd0) ? StShift : StDone;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            StShift: busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        if (accept) begin
            data_d  = in;
            count_d = shamt;
        end else if (state_q == StShift) begin
            data_d  = {fill, data_q[WIDTH-1:1]};
            count_d = count_q - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            count_q <= 5'd0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign out = data_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed self-checking bench for shift_right_seq; sign-fill expectations follow
// SHIFT_RIGHT_ARITH_EN the same way the design build does.
`timescale 1ns/1ps

module tb_shift_right_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] in;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int n_cmp;
    int n_err;

    shift_right_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (in),
        .shamt (shamt),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        in    = 32'hDEAD_BEEF;
        shamt = 5'd7;
        arith = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset: out=%h busy=%b done=%b, want out=0 busy=0 done=0", out, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL idle_hold[%0d]: out=%h busy=%b done=%b, want 0/0/0",
                         i, out, busy, done);
            end
        end
    endtask

    // Issue one operation and check busy for exactly sh cycles, then a one-cycle done with result.
    task automatic run_op(input logic [31:0] a, input logic [4:0] sh, input logic ar,
                          input logic [31:0] expected, input string name);
        in    = a;
        shamt = sh;
        arith = ar;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < int'(sh); k++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL %s busy_phase[%0d]: busy=%b done=%b, want busy=1 done=0",
                         name, k, busy, done);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || out !== expected) begin
            n_err++;
            $display("FAIL %s result: done=%b busy=%b out=%h, want done=1 busy=0 out=%h",
                     name, done, busy, out, expected);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || out !== expected) begin
            n_err++;
            $display("FAIL %s after: done=%b busy=%b out=%h, want done=0 busy=0 out=%h",
                     name, done, busy, out, expected);
        end
    endtask

    task automatic test_basic();
        run_op(32'd100, 5'd2, 1'b0, 32'd25, "basic_100_2");
        tick();
        tick();
        n_cmp++;
        if (out !== 32'd25 || done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_hold: out=%0d done=%b, want out=25 done=0", out, done);
        end
    endtask

    task automatic test_arith();
`ifdef SHIFT_RIGHT_ARITH_EN
        run_op(32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000, "sra_8000_4");
        run_op(32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF, "sra_ffff_31");
        run_op(32'h7000_0000, 5'd3, 1'b1, 32'h0E00_0000, "sra_pos_3");
`else
        run_op(32'h8000_0000, 5'd4, 1'b1, 32'h0800_0000, "sra_8000_4");
        run_op(32'hFFFF_FFFF, 5'd31, 1'b1, 32'h0000_0001, "sra_ffff_31");
        run_op(32'h7000_0000, 5'd3, 1'b1, 32'h0E00_0000, "sra_pos_3");
`endif
        run_op(32'h8000_0000, 5'd4, 1'b0, 32'h0800_0000, "srl_8000_4");
    endtask

    task automatic test_boundaries();
        run_op(32'd12100, 5'd0, 1'b0, 32'd12100, "shamt0");
        run_op(32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0000_0001, "srl_ffff_31");
        run_op(32'hA5A5_1234, 5'd16, 1'b0, 32'h0000_A5A5, "srl_16");
    endtask

    task automatic test_back_to_back();
        in    = 32'h0000_00A0;
        shamt = 5'd5;
        arith = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        // Re-request while busy; must be ignored during SHIFT, accepted from DONE.
        in    = 32'd6;
        shamt = 5'd1;
        start = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_ignore: busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || out !== 32'd5) begin
            n_err++;
            $display("FAIL b2b_first: done=%b out=%0d, want done=1 out=5", done, out);
        end
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || out !== 32'd6) begin
            n_err++;
            $display("FAIL b2b_accept: busy=%b done=%b out=%0d, want busy=1 done=0 out=6",
                     busy, done, out);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || out !== 32'd3) begin
            n_err++;
            $display("FAIL b2b_second: done=%b out=%0d, want done=1 out=3", done, out);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: done=%b busy=%b, want 0/0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        in    = 32'hFFFF_0000;
        shamt = 5'd10;
        arith = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: out=%h busy=%b done=%b, want 0/0/0", out, busy, done);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1 || out !== 32'h0) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL reset_mid_quiet: %0d active cycles after reset, want 0", pulses);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        in    = 32'h0;
        shamt = 5'd0;
        arith = 1'b0;
        test_reset();
        test_basic();
        test_arith();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
